// File: rtl/matmul_csr_ctrl.sv
// AXI4-Lite CSR block sequencing compute_wrapper: write commits one cycle after AW+W held, read data one cycle after AR.
// Single outstanding write and read; AW/W/AR ready drop while a response is pending.
module matmul_csr_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int K_MAX   = 64,
    parameter int K_RESET = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              start,
    output logic [15:0]       cfg_k,
    output logic              sw_clear_done,
    input  logic              done_pulse,
    output logic              irq
);
    localparam int RA = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [RA-1:0] A_CTRL     = RA'(0);
    localparam logic [RA-1:0] A_STATUS   = RA'(1);
    localparam logic [RA-1:0] A_CFG_K    = RA'(2);
    localparam logic [RA-1:0] A_IRQ_EN   = RA'(3);
    localparam logic [RA-1:0] A_IRQ_STAT = RA'(4);
    localparam logic [RA-1:0] A_JOB_CNT  = RA'(5);

    logic          rdy_en;
    logic          aw_held;
    logic          w_held;
    logic [RA-1:0] wr_idx;
    logic [31:0]   wr_dat;
    logic          commit;
    logic          busy;
    logic          done;
    logic          irq_en;
    logic          irq_stat;
    logic [31:0]   job_cnt;

    logic          wr_err;
    logic          start_fire;
    logic          clr_fire;
    logic          cfg_we;
    logic          irq_en_we;
    logic          irq_clr;
    logic [31:0]   rd_dat;
    logic          rd_err;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // rdy_en keeps every ready low while reset is held and for the first cycle after.
    assign s_axil_awready = rdy_en & ~aw_held & ~s_axil_bvalid;
    assign s_axil_wready  = rdy_en & ~w_held & ~s_axil_bvalid;
    assign s_axil_arready = rdy_en & ~s_axil_rvalid;
    assign commit         = aw_held & w_held;
    assign irq            = irq_en & irq_stat;

    always_comb begin
        wr_err     = 1'b0;
        start_fire = 1'b0;
        clr_fire   = 1'b0;
        cfg_we     = 1'b0;
        irq_en_we  = 1'b0;
        irq_clr    = 1'b0;
        case (wr_idx)
            A_CTRL: begin
                start_fire = wr_dat[0] & ~busy;
                clr_fire   = wr_dat[1];
            end
            A_CFG_K: begin
                if (wr_dat == 32'd0 || wr_dat > 32'(K_MAX) || busy) wr_err = 1'b1;
                else                                                cfg_we = 1'b1;
            end
            A_IRQ_EN:   irq_en_we = 1'b1;
            A_IRQ_STAT: irq_clr   = wr_dat[0];
            default:    wr_err    = 1'b1;
        endcase
    end

    always_comb begin
        rd_dat = '0;
        rd_err = 1'b0;
        case (s_axil_araddr[ADDR_W-1:2])
            A_CTRL:     rd_dat = '0;
            A_STATUS:   rd_dat = {30'd0, done, busy};
            A_CFG_K:    rd_dat = {16'd0, cfg_k};
            A_IRQ_EN:   rd_dat = {31'd0, irq_en};
            A_IRQ_STAT: rd_dat = {31'd0, irq_stat};
            A_JOB_CNT:  rd_dat = job_cnt;
            default:    rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en        <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            wr_idx        <= '0;
            wr_dat        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (s_axil_awvalid && s_axil_awready) begin
                aw_held <= 1'b1;
                wr_idx  <= s_axil_awaddr[ADDR_W-1:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held <= 1'b1;
                wr_dat <= s_axil_wdata;
            end
            if (commit) begin
                aw_held       <= 1'b0;
                w_held        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_bvalid && s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            if (s_axil_arvalid && s_axil_arready) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_dat;
                s_axil_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // A completion always lands in DONE/IRQ_STAT, beating any same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start         <= 1'b0;
            sw_clear_done <= 1'b0;
            cfg_k         <= 16'(K_RESET);
            busy          <= 1'b0;
            done          <= 1'b0;
            irq_en        <= 1'b0;
            irq_stat      <= 1'b0;
            job_cnt       <= '0;
        end else begin
            start         <= commit & start_fire;
            sw_clear_done <= commit & clr_fire;
            if (commit && cfg_we)    cfg_k  <= wr_dat[15:0];
            if (commit && irq_en_we) irq_en <= wr_dat[0];
            if (commit && start_fire)  busy <= 1'b1;
            else if (done_pulse)       busy <= 1'b0;
            if (done_pulse)                                done <= 1'b1;
            else if (commit && (start_fire || clr_fire))   done <= 1'b0;
            if (done_pulse)                irq_stat <= 1'b1;
            else if (commit && irq_clr)    irq_stat <= 1'b0;
            if (done_pulse) job_cnt <= job_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_matmul_csr_ctrl.sv
// Bench for matmul_csr_ctrl: register-map vector table, hand sequences for timing corners,
// then random traffic against an abstract register model.
module tb_matmul_csr_ctrl;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] SLV = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [7:0]  s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic        start;
    logic [15:0] cfg_k;
    logic        sw_clear_done;
    logic        done_pulse = 1'b0;
    logic        irq;

    matmul_csr_ctrl #(.ADDR_W(8), .K_MAX(64), .K_RESET(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .start(start), .cfg_k(cfg_k), .sw_clear_done(sw_clear_done),
        .done_pulse(done_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int clr_cnt = 0;
    int start_cyc = -1;
    int bv_cyc = -2;
    logic irq_at_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n && start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (rst_n && sw_clear_done) clr_cnt <= clr_cnt + 1;
    end

    // Abstract register model
    logic [15:0] m_cfg = 16'd4;
    logic        m_busy = 0, m_done = 0, m_irq_en = 0, m_stat = 0;
    logic [31:0] m_jobs = 0;
    int          m_starts = 0, m_clrs = 0;

    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d);
        case (a[7:2])
            6'd0: begin
                if (d[0] && !m_busy) begin m_busy = 1; m_done = 0; m_starts++; end
                if (d[1]) begin m_done = 0; m_clrs++; end
                return OK;
            end
            6'd2: begin
                if (d == 0 || d > 64 || m_busy) return SLV;
                m_cfg = d[15:0];
                return OK;
            end
            6'd3: begin m_irq_en = d[0]; return OK; end
            6'd4: begin if (d[0]) m_stat = 0; return OK; end
            default: return SLV;
        endcase
    endfunction

    function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        d = 0; r = OK;
        case (a[7:2])
            6'd0: d = 0;
            6'd1: d = {30'd0, m_done, m_busy};
            6'd2: d = {16'd0, m_cfg};
            6'd3: d = {31'd0, m_irq_en};
            6'd4: d = {31'd0, m_stat};
            6'd5: d = m_jobs;
            default: r = SLV;
        endcase
    endfunction

    function automatic void model_done();
        m_busy = 0; m_done = 1; m_stat = 1; m_jobs = m_jobs + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input int aw_dly, input int w_dly,
                             input int b_dly, input bit dp, output logic [1:0] resp);
        bit aw_ok = 0, w_ok = 0, stable = 1;
        int n = 0;
        logic [1:0] r0;
        while (!(aw_ok && w_ok) && n < 100) begin
            @(negedge clk);
            s_axil_awaddr  = a;
            s_axil_wdata   = d;
            s_axil_awvalid = !aw_ok && n >= aw_dly;
            s_axil_wvalid  = !w_ok && n >= w_dly;
            if (s_axil_awvalid && s_axil_awready) aw_ok = 1;
            if (s_axil_wvalid && s_axil_wready) w_ok = 1;
            n++;
        end
        if (n >= 100) chk("aw_w_timeout", 32'(aw_ok & w_ok), 32'd1);
        @(negedge clk);
        s_axil_awvalid = 0;
        s_axil_wvalid  = 0;
        done_pulse     = dp;
        @(negedge clk);
        done_pulse = 0;
        n = 0;
        while (!s_axil_bvalid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("b_timeout", 32'(s_axil_bvalid), 32'd1);
        bv_cyc   = cyc;
        irq_at_b = irq;
        r0       = s_axil_bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            if (!s_axil_bvalid || s_axil_bresp !== r0) stable = 0;
        end
        s_axil_bready = 1;
        @(negedge clk);
        s_axil_bready = 0;
        if (b_dly > 0) chk("bvalid_hold", 32'(stable), 32'd1);
        chk("bvalid_drop", 32'(s_axil_bvalid), 32'd0);
        resp = r0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int rr_dly, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        bit stable = 1;
        @(negedge clk);
        s_axil_araddr  = a;
        s_axil_arvalid = 1;
        while (!s_axil_arready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("ar_timeout", 32'(s_axil_arready), 32'd1);
        @(negedge clk);
        s_axil_arvalid = 0;
        chk("rvalid_latency", 32'(s_axil_rvalid), 32'd1);
        d = s_axil_rdata;
        r = s_axil_rresp;
        for (int i = 0; i < rr_dly; i++) begin
            @(negedge clk);
            if (!s_axil_rvalid || s_axil_rdata !== d || s_axil_rresp !== r) stable = 0;
        end
        s_axil_rready = 1;
        @(negedge clk);
        s_axil_rready = 0;
        if (rr_dly > 0) chk("rdata_hold", 32'(stable), 32'd1);
    endtask

    task automatic wr_m(input logic [7:0] a, input logic [31:0] d, input int awd, input int wd,
                        input int bd, input bit dp, output logic [1:0] resp);
        logic [1:0] er;
        axi_write(a, d, awd, wd, bd, dp, resp);
        er = model_write(a, d);
        if (dp) model_done();
        chk("bresp_model", 32'(resp), 32'(er));
    endtask

    task automatic rd_m(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ed;
        logic [1:0]  er;
        axi_read(a, $urandom_range(0, 3), d, r);
        model_read(a, ed, er);
        chk("rdata_model", d, ed);
        chk("rresp_model", 32'(r), 32'(er));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_pulse = 1;
        @(negedge clk);
        done_pulse = 0;
        model_done();
    endtask

    task automatic chk_state();
        chk("irq", 32'(irq), 32'(m_irq_en & m_stat));
        chk("start_count", 32'(start_cnt), 32'(m_starts));
        chk("clear_count", 32'(clr_cnt), 32'(m_clrs));
        chk("cfg_k_port", 32'(cfg_k), 32'(m_cfg));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        {s_axil_awvalid, s_axil_wvalid, s_axil_bready, s_axil_arvalid, s_axil_rready, done_pulse} = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", 32'({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                                start, sw_clear_done, irq, s_axil_bresp, s_axil_rresp}), 32'd0);
        chk("reset_rdata", s_axil_rdata, 32'd0);
        chk("reset_cfg_k", 32'(cfg_k), 32'd4);
        rst_n = 1;
        m_cfg = 16'd4; m_busy = 0; m_done = 0; m_irq_en = 0; m_stat = 0; m_jobs = 0;
        @(negedge clk);
    endtask

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t        tbl[19];
    logic [7:0]  addrs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'hFC};
    logic [31:0] d;
    logic [1:0]  r;
    int          s0, c0;

    initial begin
        tbl[0]  = '{0, 8'h08, 0, OK, 4};    tbl[1]  = '{0, 8'h04, 0, OK, 0};
        tbl[2]  = '{0, 8'h14, 0, OK, 0};    tbl[3]  = '{0, 8'h00, 0, OK, 0};
        tbl[4]  = '{0, 8'h20, 0, SLV, 0};   tbl[5]  = '{1, 8'h08, 0, SLV, 0};
        tbl[6]  = '{1, 8'h08, 65, SLV, 0};  tbl[7]  = '{0, 8'h08, 0, OK, 4};
        tbl[8]  = '{1, 8'h08, 64, OK, 0};   tbl[9]  = '{0, 8'h0B, 0, OK, 64};
        tbl[10] = '{1, 8'h04, 1, SLV, 0};   tbl[11] = '{1, 8'h14, 5, SLV, 0};
        tbl[12] = '{0, 8'h04, 0, OK, 0};    tbl[13] = '{1, 8'h0C, 1, OK, 0};
        tbl[14] = '{0, 8'h0C, 0, OK, 1};    tbl[15] = '{1, 8'h0C, 0, OK, 0};
        tbl[16] = '{1, 8'h1C, 3, SLV, 0};   tbl[17] = '{0, 8'h10, 0, OK, 0};
        tbl[18] = '{1, 8'h08, 4, OK, 0};

        apply_reset();
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_wr) begin
                wr_m(tbl[i].addr, tbl[i].data, 0, 0, 0, 0, r);
                chk($sformatf("tbl%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
            end else begin
                rd_m(tbl[i].addr, d, r);
                chk($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
                chk($sformatf("tbl%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
            end
        end
        chk_state();

        // Job sequencing and start timing
        wr_m(8'h08, 16, 0, 0, 0, 0, r);
        s0 = start_cnt;
        wr_m(8'h00, 1, 0, 0, 0, 0, r);
        chk("start_once", 32'(start_cnt - s0), 32'd1);
        chk("start_timing", 32'(start_cyc), 32'(bv_cyc));
        chk("cfg_k_16", 32'(cfg_k), 32'd16);
        rd_m(8'h04, d, r);  chk("status_busy", d, 32'h1);
        repeat (20) @(negedge clk);
        rd_m(8'h04, d, r);  chk("status_busy_late", d, 32'h1);
        pulse_done();
        rd_m(8'h04, d, r);  chk("status_done", d, 32'h2);
        rd_m(8'h14, d, r);  chk("job_cnt_1", d, 32'h1);

        // Interrupt set/clear including W1C colliding with done
        wr_m(8'h0C, 1, 0, 0, 0, 0, r);
        wr_m(8'h10, 1, 0, 0, 0, 0, r);
        chk("irq_low", 32'(irq), 32'd0);
        wr_m(8'h00, 1, 0, 0, 0, 0, r);
        pulse_done();
        chk("irq_set", 32'(irq), 32'd1);
        wr_m(8'h10, 1, 0, 0, 0, 0, r);
        chk("irq_w1c_next", 32'(irq_at_b), 32'd0);
        pulse_done();
        wr_m(8'h10, 1, 0, 0, 0, 1, r);
        chk("irq_set_wins", 32'(irq_at_b), 32'd1);
        rd_m(8'h10, d, r);  chk("irq_stat_kept", d, 32'h1);
        wr_m(8'h10, 1, 0, 0, 0, 0, r);
        chk_state();

        // Skewed AW/W with bready stall; single commit
        s0 = start_cnt;
        wr_m(8'h00, 1, 0, 3, 5, 0, r);
        chk("single_commit", 32'(start_cnt - s0), 32'd1);
        wr_m(8'h08, 32, 3, 0, 2, 0, r);
        chk("cfg_busy_slverr", 32'(r), 32'(SLV));
        chk("cfg_busy_kept", 32'(cfg_k), 32'd16);

        // START while busy, START colliding with done, CLR_DONE paths
        s0 = start_cnt;
        wr_m(8'h00, 1, 0, 0, 0, 0, r);
        chk("start_busy_okay", 32'(r), 32'(OK));
        wr_m(8'h00, 1, 0, 0, 0, 1, r);
        chk("start_busy_ignored", 32'(start_cnt - s0), 32'd0);
        rd_m(8'h04, d, r);  chk("status_after_collide", d, 32'h2);
        c0 = clr_cnt;
        wr_m(8'h00, 2, 0, 0, 0, 0, r);
        chk("sw_clear_once", 32'(clr_cnt - c0), 32'd1);
        rd_m(8'h04, d, r);  chk("status_cleared", d, 32'h0);
        wr_m(8'h00, 2, 0, 0, 0, 1, r);
        rd_m(8'h04, d, r);  chk("done_beats_clear", d, 32'h2);
        chk_state();

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            int op, ai;
            logic [7:0] a;
            op = $urandom_range(0, 9);
            ai = $urandom_range(0, 8);
            a  = addrs[ai] | 8'($urandom_range(0, 3));
            if (op < 4) begin
                if (ai == 2)           d = $urandom_range(0, 80);
                else if ($urandom % 4 == 0) d = $urandom;
                else                   d = $urandom_range(0, 3);
                wr_m(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0, r);
            end else if (op < 8) begin
                rd_m(a, d, r);
            end else begin
                pulse_done();
            end
            chk_state();
        end

        // Reset with a job running, a write half-captured and a read response pending
        if (!m_busy) wr_m(8'h00, 1, 0, 0, 0, 0, r);
        @(negedge clk);
        s_axil_awaddr = 8'h0C; s_axil_awvalid = 1;
        s_axil_araddr = 8'h14; s_axil_arvalid = 1;
        @(negedge clk);
        s_axil_awvalid = 0; s_axil_arvalid = 0;
        apply_reset();
        chk("no_stale_bvalid", 32'(s_axil_bvalid | s_axil_rvalid), 32'd0);
        rd_m(8'h04, d, r);  chk("status_after_rst", d, 32'h0);
        rd_m(8'h14, d, r);  chk("jobs_after_rst", d, 32'h0);
        rd_m(8'h0C, d, r);  chk("irq_en_after_rst", d, 32'h0);
        chk_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
